// File: rtl/pulse_width_monitor_if.sv
// pulse_width_monitor_if
//   Bundles the monitored signals, run-time configuration and the
//   violation/error reporting of pulse_width_monitor.
//   Ports of the monitor (slave modport):
//     sig_in, ch_en        per-channel monitored signals and check enables
//     cfg_max_high         max legal consecutive high samples (0 = off)
//     cfg_min_low          min low samples between pulses (0 = off)
//     err_clr              clears err_sticky / err_count (and first-error capture)
//     viol_long, viol_gap  per-channel 1-cycle violation strobes
//     err_sticky           per-channel sticky error flags
//     err_count            saturating total violation count
//   Build option: PULSE_MON_FIRST_ERR_EN adds first_err_valid,
//   first_err_ch and first_err_type.
interface pulse_width_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int ERR_W  = 16
);
  localparam int FE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] sig_in;
  logic [NUM_CH-1:0] ch_en;
  logic [CNT_W-1:0]  cfg_max_high;
  logic [CNT_W-1:0]  cfg_min_low;
  logic              err_clr;
  logic [NUM_CH-1:0] viol_long;
  logic [NUM_CH-1:0] viol_gap;
  logic [NUM_CH-1:0] err_sticky;
  logic [ERR_W-1:0]  err_count;
`ifdef PULSE_MON_FIRST_ERR_EN
  logic              first_err_valid;
  logic [FE_W-1:0]   first_err_ch;
  logic              first_err_type;

  modport master (
    output sig_in, ch_en, cfg_max_high, cfg_min_low, err_clr,
    input  viol_long, viol_gap, err_sticky, err_count,
    input  first_err_valid, first_err_ch, first_err_type
  );
  modport slave (
    input  sig_in, ch_en, cfg_max_high, cfg_min_low, err_clr,
    output viol_long, viol_gap, err_sticky, err_count,
    output first_err_valid, first_err_ch, first_err_type
  );
`else
  modport master (
    output sig_in, ch_en, cfg_max_high, cfg_min_low, err_clr,
    input  viol_long, viol_gap, err_sticky, err_count
  );
  modport slave (
    input  sig_in, ch_en, cfg_max_high, cfg_min_low, err_clr,
    output viol_long, viol_gap, err_sticky, err_count
  );
`endif
endinterface

// File: rtl/pulse_width_monitor.sv
// pulse_width_monitor
//   Multi-channel pulse-shape checker. Each channel checks the maximum
//   consecutive high width and the minimum low gap between pulses, raising
//   registered 1-cycle strobes, sticky flags and a saturating total count.
//   Ports:
//     clk    clock, all sampling on posedge
//     reset  synchronous active-high reset
//     mon    pulse_width_monitor_if.slave (signals, config, error outputs)
//   Build option: define PULSE_MON_FIRST_ERR_EN to capture the first
//   violation (channel and type) after reset or err_clr.
module pulse_width_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int ERR_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pulse_width_monitor_if.slave  mon
);

  localparam int PC_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2} state_t;

  logic [NUM_CH-1:0] long_ev;
  logic [NUM_CH-1:0] gap_ev;

  // ---------------------------------------------------------------------
  // Per-channel FSMs
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] hcnt_reg, hcnt_next;
      logic [CNT_W-1:0] lcnt_reg, lcnt_next;
      // Set once the current pulse has reported its long violation so a
      // long (possibly saturated) pulse never re-fires.
      logic             fired_reg, fired_next;
      logic             en;
      logic             s;

      assign en = mon.ch_en[gi];
      assign s  = mon.sig_in[gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= IDLE;
          hcnt_reg  <= '0;
          lcnt_reg  <= '0;
          fired_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          hcnt_reg  <= hcnt_next;
          lcnt_reg  <= lcnt_next;
          fired_reg <= fired_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        lcnt_next  = lcnt_reg;
        fired_next = fired_reg;
        if (!en) begin
          state_next = IDLE;
          hcnt_next  = '0;
          lcnt_next  = '0;
          fired_next = 1'b0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (s) begin
                state_next = HIGH;
                hcnt_next  = CNT_W'(1);
                lcnt_next  = '0;
                fired_next = 1'b0;
              end
            end
            HIGH: begin
              if (s) begin
                hcnt_next = (hcnt_reg == CNT_MAX) ? hcnt_reg : hcnt_reg + CNT_W'(1);
                if (long_ev[gi]) fired_next = 1'b1;
              end else begin
                hcnt_next  = '0;
                lcnt_next  = CNT_W'(1);
                fired_next = 1'b0;
                state_next = (mon.cfg_min_low <= CNT_W'(1)) ? IDLE : GAP;
              end
            end
            GAP: begin
              if (s) begin
                state_next = HIGH;
                hcnt_next  = CNT_W'(1);
                lcnt_next  = '0;
                fired_next = 1'b0;
              end else begin
                lcnt_next = (lcnt_reg == CNT_MAX) ? lcnt_reg : lcnt_reg + CNT_W'(1);
                // Compare one bit wider so lcnt+1 cannot wrap.
                if (({1'b0, lcnt_reg} + (CNT_W+1)'(1)) >= {1'b0, mon.cfg_min_low})
                  state_next = IDLE;
              end
            end
            default: state_next = IDLE;
          endcase
        end
      end

      // Violation events for this sample; registered centrally below.
      // Entering HIGH always sets hcnt=1, so a long event (which needs
      // hcnt_reg>=1 while already in HIGH) can never coincide with a gap event.
      always_comb begin
        long_ev[gi] = en && (state_reg == HIGH) && s && (mon.cfg_max_high != '0)
                      && !fired_reg && (hcnt_reg >= mon.cfg_max_high);
        gap_ev[gi]  = en && (state_reg == GAP) && s && (lcnt_reg < mon.cfg_min_low);
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Aggregate error reporting
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] viol_long_reg, viol_gap_reg;
  logic [NUM_CH-1:0] sticky_reg, sticky_next;
  logic [ERR_W-1:0]  count_reg, count_next;
  logic [NUM_CH-1:0] viol_any;
  logic [PC_W-1:0]   pop;
  logic [ERR_W:0]    sum;

  assign viol_any = long_ev | gap_ev;

  // err_clr wipes the old state first, then this cycle's events are applied.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + PC_W'(viol_any[i]);
    sum = {1'b0, (mon.err_clr ? '0 : count_reg)} + (ERR_W+1)'(pop);
    count_next  = (sum > {1'b0, ERR_MAX}) ? ERR_MAX : sum[ERR_W-1:0];
    sticky_next = (mon.err_clr ? '0 : sticky_reg) | viol_any;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      viol_long_reg <= '0;
      viol_gap_reg  <= '0;
      sticky_reg    <= '0;
      count_reg     <= '0;
    end else begin
      viol_long_reg <= long_ev;
      viol_gap_reg  <= gap_ev;
      sticky_reg    <= sticky_next;
      count_reg     <= count_next;
    end
  end

  assign mon.viol_long  = viol_long_reg;
  assign mon.viol_gap   = viol_gap_reg;
  assign mon.err_sticky = sticky_reg;
  assign mon.err_count  = count_reg;

`ifdef PULSE_MON_FIRST_ERR_EN
  localparam int FE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            fe_valid_reg, fe_valid_next;
  logic [FE_W-1:0] fe_ch_reg, fe_ch_next;
  logic            fe_type_reg, fe_type_next;

  always_comb begin
    fe_valid_next = fe_valid_reg;
    fe_ch_next    = fe_ch_reg;
    fe_type_next  = fe_type_reg;
    if (mon.err_clr) begin
      fe_valid_next = 1'b0;
      fe_ch_next    = '0;
      fe_type_next  = 1'b0;
    end
    if (!fe_valid_next && (viol_any != '0)) begin
      fe_valid_next = 1'b1;
      // Scan downward so the lowest violating channel is the last written.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (viol_any[i]) begin
          fe_ch_next   = FE_W'(i);
          fe_type_next = gap_ev[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fe_valid_reg <= 1'b0;
      fe_ch_reg    <= '0;
      fe_type_reg  <= 1'b0;
    end else begin
      fe_valid_reg <= fe_valid_next;
      fe_ch_reg    <= fe_ch_next;
      fe_type_reg  <= fe_type_next;
    end
  end

  assign mon.first_err_valid = fe_valid_reg;
  assign mon.first_err_ch    = fe_ch_reg;
  assign mon.first_err_type  = fe_type_reg;
`endif

endmodule

// File: tb/tb_pulse_width_monitor.sv
// tb_pulse_width_monitor
//   Directed-vector bench for pulse_width_monitor (NUM_CH=4, CNT_W=8,
//   ERR_W=16). Expected values are hand-computed from the pulse rules.
module tb_pulse_width_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   long_cnt [4];
  int   gap_cnt  [4];

  always #5 clk = ~clk;

  pulse_width_monitor_if #(.NUM_CH(4), .CNT_W(8), .ERR_W(16)) bus ();

  pulse_width_monitor #(.NUM_CH(4), .CNT_W(8), .ERR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Apply one sample, clock it, then look at the registered outputs.
  task automatic cyc(input logic [3:0] s);
    bus.sig_in = s;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      long_cnt[i] += int'(bus.viol_long[i]);
      gap_cnt[i]  += int'(bus.viol_gap[i]);
    end
  endtask

  task automatic clr_acc();
    for (int i = 0; i < 4; i++) begin
      long_cnt[i] = 0;
      gap_cnt[i]  = 0;
    end
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    cyc(4'b0000);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    bus.sig_in       = '0;
    bus.ch_en        = '0;
    bus.cfg_max_high = 8'd1;
    bus.cfg_min_low  = 8'd1;
    bus.err_clr      = 1'b0;
    clr_acc();

    // Reset state
    repeat (3) cyc(4'b0000);
    check("rst_viol_long", 32'(bus.viol_long), 32'h0);
    check("rst_viol_gap", 32'(bus.viol_gap), 32'h0);
    check("rst_sticky", 32'(bus.err_sticky), 32'h0);
    check("rst_count", 32'(bus.err_count), 32'h0);
    reset = 1'b0;
    bus.ch_en = 4'hF;
    cyc(4'b0000);

    // cfg 1/1: legal single-cycle pulses
    clr_acc();
    cyc(4'b0001); cyc(4'b0000); cyc(4'b0000); cyc(4'b0001); cyc(4'b0000); cyc(4'b0000);
    check("legal_long_strobes", 32'(long_cnt[0]), 32'd0);
    check("legal_gap_strobes", 32'(gap_cnt[0]), 32'd0);
    check("legal_count", 32'(bus.err_count), 32'd0);

    // cfg 1/1: held high 3 cycles -> single long strobe after 2nd sample
    clr_acc();
    cyc(4'b0001);
    check("hold_s1_long", 32'(bus.viol_long), 32'h0);
    cyc(4'b0001);
    check("hold_s2_long", 32'(bus.viol_long), 32'h1);
    cyc(4'b0001);
    check("hold_s3_long", 32'(bus.viol_long), 32'h0);
    cyc(4'b0000); cyc(4'b0000);
    check("hold_long_total", 32'(long_cnt[0]), 32'd1);
    check("hold_sticky", 32'(bus.err_sticky), 32'h1);
    check("hold_count", 32'(bus.err_count), 32'd1);
`ifdef PULSE_MON_FIRST_ERR_EN
    check("hold_fe_valid", 32'(bus.first_err_valid), 32'd1);
    check("hold_fe_ch", 32'(bus.first_err_ch), 32'd0);
    check("hold_fe_type", 32'(bus.first_err_type), 32'd0);
`endif
    pulse_err_clr();
    check("clr_count", 32'(bus.err_count), 32'd0);
    check("clr_sticky", 32'(bus.err_sticky), 32'h0);

    // cfg 4/3, ch2: gap violation then a 5-cycle high long violation
    bus.cfg_max_high = 8'd4;
    bus.cfg_min_low  = 8'd3;
    clr_acc();
    cyc(4'b0100); cyc(4'b0100); cyc(4'b0000); cyc(4'b0100);
    check("gap_strobe", 32'(bus.viol_gap), 32'h4);
    cyc(4'b0000); cyc(4'b0000); cyc(4'b0000);
    cyc(4'b0100); cyc(4'b0100); cyc(4'b0100); cyc(4'b0100);
    check("long4_no_strobe", 32'(bus.viol_long), 32'h0);
    cyc(4'b0100);
    check("long5_strobe", 32'(bus.viol_long), 32'h4);
    cyc(4'b0000); cyc(4'b0000); cyc(4'b0000);
    check("ch2_long_total", 32'(long_cnt[2]), 32'd1);
    check("ch2_gap_total", 32'(gap_cnt[2]), 32'd1);
    check("ch2_count", 32'(bus.err_count), 32'd2);
    check("ch2_sticky", 32'(bus.err_sticky), 32'h4);
`ifdef PULSE_MON_FIRST_ERR_EN
    check("ch2_fe_ch", 32'(bus.first_err_ch), 32'd2);
    check("ch2_fe_type", 32'(bus.first_err_type), 32'd1);
`endif

    // err_clr together with a ch1 gap violation
    cyc(4'b0010); cyc(4'b0000);
    bus.err_clr = 1'b1;
    cyc(4'b0010);
    bus.err_clr = 1'b0;
    check("clrgap_strobe", 32'(bus.viol_gap), 32'h2);
    check("clrgap_count", 32'(bus.err_count), 32'd1);
    check("clrgap_sticky", 32'(bus.err_sticky), 32'h2);
`ifdef PULSE_MON_FIRST_ERR_EN
    check("clrgap_fe_ch", 32'(bus.first_err_ch), 32'd1);
    check("clrgap_fe_type", 32'(bus.first_err_type), 32'd1);
`endif
    cyc(4'b0000); cyc(4'b0000); cyc(4'b0000);

    // Saturation: pump gap violations (cfg 0/2) up to 0xFFFE
    pulse_err_clr();
    bus.cfg_max_high = 8'd0;
    bus.cfg_min_low  = 8'd2;
    cyc(4'b1111);
    for (int n = 0; n < 16383; n++) begin
      cyc(4'b0000);
      cyc(4'b1111);
    end
    check("pump_count", 32'(bus.err_count), 32'hFFFC);
    cyc(4'b0000);
    cyc(4'b0011);
    check("pump_fffe", 32'(bus.err_count), 32'hFFFE);
    cyc(4'b0000); cyc(4'b0000); cyc(4'b0000);
    bus.cfg_max_high = 8'd1;
    bus.cfg_min_low  = 8'd1;
    cyc(4'b1001);
    cyc(4'b1001);
    check("sat_strobes", 32'(bus.viol_long), 32'h9);
    check("sat_count", 32'(bus.err_count), 32'hFFFF);
    cyc(4'b1001);
    check("sat_hold", 32'(bus.err_count), 32'hFFFF);
    cyc(4'b0000);
    pulse_err_clr();
    cyc(4'b1001);
    cyc(4'b1001);
    check("tie_count", 32'(bus.err_count), 32'd2);
`ifdef PULSE_MON_FIRST_ERR_EN
    check("tie_fe_ch", 32'(bus.first_err_ch), 32'd0);
    check("tie_fe_type", 32'(bus.first_err_type), 32'd0);
`endif
    cyc(4'b0000);

    // Reset mid-pulse, disabled channel toggling, fresh pulse on re-enable
    cyc(4'b0010);
    reset = 1'b1;
    cyc(4'b0010); cyc(4'b0010);
    check("mid_rst_sticky", 32'(bus.err_sticky), 32'h0);
    check("mid_rst_count", 32'(bus.err_count), 32'd0);
    reset = 1'b0;
    bus.ch_en = 4'b1101;
    clr_acc();
    cyc(4'b0010); cyc(4'b0010); cyc(4'b0000); cyc(4'b0010); cyc(4'b0010);
    check("dis_strobes", 32'(long_cnt[1] + gap_cnt[1]), 32'd0);
    check("dis_count", 32'(bus.err_count), 32'd0);
    bus.ch_en = 4'hF;
    cyc(4'b0010);
    check("reen_viol", 32'(bus.viol_long | bus.viol_gap), 32'h0);
    cyc(4'b0000);
    check("reen_total", 32'(long_cnt[1] + gap_cnt[1]), 32'd0);
    check("reen_sticky", 32'(bus.err_sticky), 32'h0);
`ifdef PULSE_MON_FIRST_ERR_EN
    check("reen_fe_valid", 32'(bus.first_err_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
